// File: rtl/axi4_pkg.sv
// Shared AXI4 response encodings used by every AXI slave in the codebase.
package axi4_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/axi4l_slave_regs_pkg.sv
// State encodings for the AXI4-Lite register slave write and read paths.
package axi4l_slave_regs_pkg;
  typedef enum logic {W_COLLECT, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_RESP} rd_state_e;
endpackage

// File: rtl/axi4l_slave_regs_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4l_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4l_slave_regs_reg_bank.sv
// Register storage with a byte-enabled write port, combinational read port
// and a one-cycle write pulse per register.
module axi4l_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           we_i,
  input  logic [IDX_W-1:0]               wr_idx_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
  input  logic [IDX_W-1:0]               rd_idx_i,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            reg_wr_o
);
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   reg_wr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      reg_wr_q <= '0;
    end else begin
      reg_wr_q <= '0;
      if (we_i) begin
        reg_wr_q[wr_idx_i] <= 1'b1;
        for (int j = 0; j < DATA_WIDTH/8; j++)
          if (wstrb_i[j]) regs_q[wr_idx_i][j*8 +: 8] <= wdata_i[j*8 +: 8];
      end
    end
  end

  assign rdata_o  = regs_q[rd_idx_i];
  assign reg_wr_o = reg_wr_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end
endmodule

// File: rtl/axi4l_slave_regs.sv
// AXI4-Lite slave front end: AW/W capture, write/read FSMs, address decode
// and response generation around axi4l_reg_bank.
module axi4l_slave_regs
  import axi4_pkg::*;
  import axi4l_slave_regs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  axi4l_if.slave                         s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            reg_wr
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int HI_LSB   = ADDR_LSB + IDX_W;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic                  ready_en_q;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, bank_rdata;
  logic                  bank_we, aw_hs, w_hs, ar_hs, rd_in_range;
  logic                  unused_prot;

  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};
  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid && s_axi.wready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign rd_in_range = ((s_axi.araddr >> HI_LSB) == '0);

  // ready_en_q keeps the readies low through the first edge after reset release
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ready_en_q <= 1'b0;
      wr_state_q <= W_COLLECT;
      rd_state_q <= R_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Commit happens on the edge where both halves are available, latched or live
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    bank_we    = 1'b0;
    case (wr_state_q)
      W_COLLECT: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.wdata;
          wstrb_d  = s_axi.wstrb;
        end
        if (aw_held_d && w_held_d) begin
          wr_state_d = W_RESP;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          if ((awaddr_d >> HI_LSB) == '0) begin
            bank_we = 1'b1;
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end
      end
      W_RESP: if (s_axi.bready) wr_state_d = W_COLLECT;
      default: wr_state_d = W_COLLECT;
    endcase
  end

  always_comb begin
    s_axi.awready = ready_en_q && !aw_held_q && (wr_state_q == W_COLLECT);
    s_axi.wready  = ready_en_q && !w_held_q && (wr_state_q == W_COLLECT);
    s_axi.bvalid  = (wr_state_q == W_RESP);
    s_axi.bresp   = bresp_q;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: if (ar_hs) begin
        rd_state_d = R_RESP;
        rdata_d    = rd_in_range ? bank_rdata : '0;
        rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      R_RESP: if (s_axi.rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = ready_en_q && (rd_state_q == R_IDLE);
    s_axi.rvalid  = (rd_state_q == R_RESP);
    s_axi.rdata   = rdata_q;
    s_axi.rresp   = rresp_q;
  end

  axi4l_reg_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W)
  ) u_bank (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .we_i    (bank_we),
    .wr_idx_i(awaddr_d[ADDR_LSB +: IDX_W]),
    .wdata_i (wdata_d),
    .wstrb_i (wstrb_d),
    .rd_idx_i(s_axi.araddr[ADDR_LSB +: IDX_W]),
    .rdata_o (bank_rdata),
    .regs_o  (regs_out),
    .reg_wr_o(reg_wr)
  );
endmodule

// File: tb/tb_axi4l_slave_regs.sv
// Scoreboard bench for axi4l_slave_regs: expected B/R responses are queued at
// issue time and checked by an independent monitor.
module tb_axi4l_slave_regs;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [NR*DW-1:0] regs_out;
  logic [NR-1:0]    reg_wr;

  axi4l_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi4l_slave_regs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi   (axi),
    .regs_out(regs_out),
    .reg_wr  (reg_wr)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  int pulse_cnt [NR];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return regs_out[i*DW +: DW];
  endfunction

  function automatic int pulse_total();
    int s = 0;
    for (int i = 0; i < NR; i++) s += pulse_cnt[i];
    return s;
  endfunction

  task automatic clear_pulses();
    for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
  endtask

  // Monitor: compares every B/R handshake against the head of its queue
  always @(negedge aclk) begin
    if (aresetn) begin
      for (int i = 0; i < NR; i++) if (reg_wr[i]) pulse_cnt[i]++;
      if (axi.bvalid && axi.bready) begin
        if (bq.size() == 0) chk("unexpected_b", 64'(axi.bresp), 64'hFFFF);
        else chk("bresp", 64'(axi.bresp), 64'(bq.pop_front()));
      end
      if (axi.rvalid && axi.rready) begin
        if (rq.size() == 0) chk("unexpected_r", 64'({axi.rdata, axi.rresp}), 64'hFFFF_FFFF_FFFF);
        else chk("rdata_rresp", 64'({axi.rdata, axi.rresp}), 64'(rq.pop_front()));
      end
    end
  end

  task automatic send_aw(input logic [AW-1:0] a);
    int n = 0;
    axi.awaddr = a; axi.awvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!axi.awready && n < 50);
    if (!axi.awready) chk("aw_timeout", 64'(axi.awready), 64'd1);
    @(posedge aclk); #1 axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [3:0] s);
    int n = 0;
    axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!axi.wready && n < 50);
    if (!axi.wready) chk("w_timeout", 64'(axi.wready), 64'd1);
    @(posedge aclk); #1 axi.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a);
    int n = 0;
    axi.araddr = a; axi.arvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!axi.arready && n < 50);
    if (!axi.arready) chk("ar_timeout", 64'(axi.arready), 64'd1);
    @(posedge aclk); #1 axi.arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] s, input logic [1:0] resp);
    bq.push_back(resp);
    fork
      send_aw(a);
      send_w(d, s);
    join
    @(negedge aclk);
    chk("b_latency", 64'(axi.bvalid), 64'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] resp);
    rq.push_back({d, resp});
    send_ar(a);
    @(negedge aclk);
    chk("r_latency", 64'(axi.rvalid), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin @(negedge aclk); n++; end
    if (bq.size() != 0 || rq.size() != 0) begin
      chk("resp_timeout", 64'(bq.size() + rq.size()), 64'd0);
      bq.delete(); rq.delete();
    end
    @(posedge aclk); #1;
  endtask

  logic [NR*DW-1:0] snap;

  initial begin
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b1;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
    clear_pulses();

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_readies", 64'({axi.awready, axi.wready, axi.arready}), 64'd0);
    chk("rst_valids", 64'({axi.bvalid, axi.rvalid, axi.bresp, axi.rresp}), 64'd0);
    chk("rst_regs", 64'(regs_out == '0), 64'd1);
    @(posedge aclk); #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("rel_readies_low", 64'({axi.awready, axi.wready, axi.arready}), 64'd0);
    @(negedge aclk);
    chk("rel_readies_high", 64'({axi.awready, axi.wready, axi.arready}), 64'b111);
    @(posedge aclk); #1;

    // Same-cycle AW/W write, then read back
    clear_pulses();
    do_write(32'h04, 32'hDEADBEEF, 4'hF, OKAY);
    wait_idle();
    chk("t1_pulse_r1", 64'(pulse_cnt[1]), 64'd1);
    chk("t1_pulse_total", 64'(pulse_total()), 64'd1);
    do_read(32'h04, 32'hDEADBEEF, OKAY);
    wait_idle();

    // W three cycles ahead of AW
    bq.push_back(OKAY);
    send_w(32'h12345678, 4'hF);
    @(negedge aclk);
    chk("t2_wready_held", 64'({axi.wready, axi.awready, axi.bvalid}), 64'b010);
    repeat (2) @(posedge aclk);
    #1 send_aw(32'h08);
    @(negedge aclk);
    chk("t2_b_latency", 64'(axi.bvalid), 64'd1);
    wait_idle();
    chk("t2_word2", 64'(word(2)), 64'h12345678);

    // Byte strobes
    do_write(32'h00, 32'h11111111, 4'hF, OKAY);
    wait_idle();
    do_write(32'h00, 32'hAABBCCDD, 4'b0101, OKAY);
    wait_idle();
    chk("t3_word0", 64'(word(0)), 64'h11BB11DD);
    do_read(32'h00, 32'h11BB11DD, OKAY);
    wait_idle();

    // Out-of-range write and read
    snap = regs_out;
    clear_pulses();
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, SLVERR);
    wait_idle();
    chk("t4_regs_unchanged", 64'(regs_out == snap), 64'd1);
    chk("t4_no_pulse", 64'(pulse_total()), 64'd0);
    do_read(32'h40, 32'h0, SLVERR);
    wait_idle();

    // B backpressure
    axi.bready = 1'b0;
    do_write(32'h0C, 32'hCAFEF00D, 4'hF, OKAY);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge aclk);
      chk("t5_b_stall", 64'({axi.bvalid, axi.bresp, axi.awready, axi.wready}), 64'({1'b1, OKAY, 2'b00}));
    end
    @(posedge aclk); #1 axi.bready = 1'b1;
    wait_idle();
    chk("t5_word3", 64'(word(3)), 64'hCAFEF00D);
    do_write(32'h10, 32'h0BADF00D, 4'hF, OKAY);
    wait_idle();
    chk("t5_word4", 64'(word(4)), 64'h0BADF00D);

    // wstrb = 0 still pulses and answers OKAY
    clear_pulses();
    do_write(32'h0C, 32'hFFFFFFFF, 4'h0, OKAY);
    wait_idle();
    chk("t6_word3_kept", 64'(word(3)), 64'hCAFEF00D);
    chk("t6_pulse_r3", 64'(pulse_cnt[3]), 64'd1);

    // Read and write of the same register on the same edge
    bq.push_back(OKAY);
    rq.push_back({32'hDEADBEEF, OKAY});
    fork
      send_aw(32'h04);
      send_w(32'h55555555, 4'hF);
      send_ar(32'h04);
    join
    wait_idle();
    chk("t7_word1", 64'(word(1)), 64'h55555555);
    do_read(32'h04, 32'h55555555, OKAY);
    wait_idle();

    // Reset with W held and AW pending
    send_w(32'hFFFFFFFF, 4'hF);
    axi.awaddr = 32'h14; axi.awvalid = 1'b1; aresetn = 1'b0;
    @(posedge aclk); #1 axi.awvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("t8_readies_low", 64'({axi.awready, axi.wready, axi.arready}), 64'd0);
    chk("t8_bvalid", 64'(axi.bvalid), 64'd0);
    chk("t8_regs_zero", 64'(regs_out == '0), 64'd1);
    @(negedge aclk);
    chk("t8_readies_high", 64'({axi.awready, axi.wready, axi.arready, axi.bvalid}), 64'b1110);
    repeat (3) @(negedge aclk);
    chk("t8_no_b", 64'(axi.bvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
